// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned STARVE_MAX_DEF = 3;
  localparam int unsigned DATA_W         = 32;

  // Counter width able to hold 0..max (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max > 0) ? $clog2(max + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and single-port memory command/response.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [1:0]        d_size;
  logic              d_signed;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic              mem_signed;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters plus the memory: drive requests and read data, see grants/commands.
  modport master (
    output if_req, if_addr, if_flush,
    output d_req, d_we, d_addr, d_wdata, d_size, d_signed,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_size, mem_signed
  );

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_req, d_we, d_addr, d_wdata, d_size, d_signed,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_size, mem_signed
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch is waiting.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CNT_W = cnt_width(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  // Clear wins over increment; hold once saturated.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      starve_cnt <= '0;
    end else if (inc && !sat) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign sat = (starve_cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage.
// Data has priority; a starvation counter forces one fetch through after
// STARVE_MAX back-to-back data grants. Responses return one cycle after grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  owner_e owner;
  owner_e owner_nxt;
  logic   if_drop;
  logic   if_drop_nxt;
  logic   if_gnt_c;
  logic   d_gnt_c;
  logic   starve_sat;
  logic   starve_inc;
  logic   starve_clr;

  assign starve_inc = d_gnt_c & bus.if_req;
  assign starve_clr = if_gnt_c | ~bus.if_req;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .sat (starve_sat)
  );

  // Owner of the access whose read data arrives next cycle, plus fetch-flush marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= OWN_NONE;
      if_drop <= 1'b0;
    end else begin
      owner   <= owner_nxt;
      if_drop <= if_drop_nxt;
    end
  end

  // Arbitration: data first unless the fetch has been starved long enough.
  always_comb begin
    if_gnt_c    = 1'b0;
    d_gnt_c     = 1'b0;
    owner_nxt   = OWN_NONE;
    if_drop_nxt = 1'b0;
    if (!rst) begin
      if (bus.if_req && (starve_sat || !bus.d_req)) begin
        if_gnt_c = 1'b1;
      end else if (bus.d_req) begin
        d_gnt_c = 1'b1;
      end
    end
    if (if_gnt_c) begin
      owner_nxt = OWN_IF;
    end else if (d_gnt_c) begin
      owner_nxt = OWN_DATA;
    end
    if_drop_nxt = if_gnt_c & bus.if_flush;
  end

  // Memory command mux and response steering.
  always_comb begin
    bus.if_gnt     = if_gnt_c;
    bus.d_gnt      = d_gnt_c;
    bus.mem_en     = if_gnt_c | d_gnt_c;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = ADDR_W'(0);
    bus.mem_wdata  = DATA_W'(0);
    bus.mem_size   = 2'b00;
    bus.mem_signed = 1'b0;
    bus.if_rvalid  = 1'b0;
    bus.if_rdata   = DATA_W'(0);
    bus.d_rvalid   = 1'b0;
    bus.d_rdata    = DATA_W'(0);
    if (if_gnt_c) begin
      bus.mem_addr = bus.if_addr;
      bus.mem_size = SIZE_WORD;
    end else if (d_gnt_c) begin
      bus.mem_we     = bus.d_we;
      bus.mem_addr   = bus.d_addr;
      bus.mem_wdata  = bus.d_wdata;
      bus.mem_size   = bus.d_size;
      bus.mem_signed = bus.d_signed;
    end
    // A flush at grant time or now kills the fetch response; data is untouched.
    if (!rst && owner == OWN_IF) begin
      bus.if_rvalid = ~if_drop & ~bus.if_flush;
      bus.if_rdata  = bus.mem_rdata;
    end
    if (!rst && owner == OWN_DATA) begin
      bus.d_rvalid = 1'b1;
      bus.d_rdata  = bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word-addressed memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic        e_if_rvalid;
    logic        c_if_rdata;
    logic [31:0] e_if_rdata;
    logic        e_d_rvalid;
    logic        c_d_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(
    .STARVE_MAX (3),
    .ADDR_W     (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: unwritten word i reads as C0DE_0000 + i; read data one cycle after mem_en.
  bit [31:0] mem_q    [0:63];
  bit        wr_valid [0:63];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem_q[bus.mem_addr[7:2]]    <= bus.mem_wdata;
        wr_valid[bus.mem_addr[7:2]] <= 1'b1;
      end
      bus.mem_rdata <= wr_valid[bus.mem_addr[7:2]] ? mem_q[bus.mem_addr[7:2]]
                                                   : 32'hC0DE_0000 + 32'(bus.mem_addr[7:2]);
    end
  end

  function automatic vec_t mk(
    input logic r, input logic ir, input logic [31:0] ia, input logic fl,
    input logic dr, input logic we, input logic [31:0] da, input logic [31:0] wd,
    input logic eig, input logic edg, input logic ewe, input logic [31:0] eaddr,
    input logic eirv, input logic cird, input logic [31:0] eird,
    input logic edrv, input logic cdrd, input logic [31:0] edrd);
    vec_t v;
    v.rst = r;       v.if_req = ir;     v.if_addr = ia;   v.if_flush = fl;
    v.d_req = dr;    v.d_we = we;       v.d_addr = da;    v.d_wdata = wd;
    v.e_if_gnt = eig; v.e_d_gnt = edg;  v.e_mem_en = eig | edg;
    v.e_mem_we = ewe; v.e_mem_addr = eaddr;
    v.e_if_rvalid = eirv; v.c_if_rdata = cird; v.e_if_rdata = eird;
    v.e_d_rvalid = edrv;  v.c_d_rdata = cdrd;  v.e_d_rdata = edrd;
    return v;
  endfunction

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s actual=%h required=%h", tag, nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge and check this cycle's outputs.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    rst          = v.rst;
    bus.if_req   = v.if_req;
    bus.if_addr  = v.if_addr;
    bus.if_flush = v.if_flush;
    bus.d_req    = v.d_req;
    bus.d_we     = v.d_we;
    bus.d_addr   = v.d_addr;
    bus.d_wdata  = v.d_wdata;
    bus.d_size   = SIZE_WORD;
    bus.d_signed = 1'b0;
    #1;
    chk(tag, "if_gnt",    32'(bus.if_gnt),    32'(v.e_if_gnt));
    chk(tag, "d_gnt",     32'(bus.d_gnt),     32'(v.e_d_gnt));
    chk(tag, "mem_en",    32'(bus.mem_en),    32'(v.e_mem_en));
    chk(tag, "mem_we",    32'(bus.mem_we),    32'(v.e_mem_we));
    chk(tag, "mem_addr",  bus.mem_addr,       v.e_mem_addr);
    if (v.e_mem_we) chk(tag, "mem_wdata", bus.mem_wdata, v.d_wdata);
    chk(tag, "if_rvalid", 32'(bus.if_rvalid), 32'(v.e_if_rvalid));
    if (v.c_if_rdata) chk(tag, "if_rdata", bus.if_rdata, v.e_if_rdata);
    chk(tag, "d_rvalid",  32'(bus.d_rvalid),  32'(v.e_d_rvalid));
    if (v.c_d_rdata) chk(tag, "d_rdata", bus.d_rdata, v.e_d_rdata);
  endtask

  vec_t tbl [0:15];
  vec_t flush_seq [0:6];
  vec_t rst_seq [0:4];

  initial begin
    checks   = 0;
    failures = 0;

    // Reset, fetch stream, starvation pattern, store then load-back.
    //            rst ir ia        fl dr we da        wd            eig edg ewe eaddr     eirv cird eird          edrv cdrd edrd
    tbl[0]  = mk(1, 1, 32'h00, 0, 1, 0, 32'h20, 32'h0,        0, 0, 0, 32'h00, 0, 1, 32'h0,         0, 1, 32'h0);
    tbl[1]  = mk(0, 1, 32'h00, 0, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h00, 0, 0, 32'h0,         0, 0, 32'h0);
    tbl[2]  = mk(0, 1, 32'h04, 0, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h04, 1, 1, 32'hC0DE0000,  0, 0, 32'h0);
    tbl[3]  = mk(0, 1, 32'h08, 0, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h08, 1, 1, 32'hC0DE0001,  0, 0, 32'h0);
    tbl[4]  = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 1, 1, 32'hC0DE0002,  0, 0, 32'h0);
    tbl[5]  = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 0, 0, 32'h0,         0, 0, 32'h0);
    tbl[6]  = mk(0, 1, 32'h0C, 0, 1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 0, 0, 32'h0,         0, 0, 32'h0);
    tbl[7]  = mk(0, 1, 32'h0C, 0, 1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 0, 0, 32'h0,         1, 1, 32'hC0DE0008);
    tbl[8]  = mk(0, 1, 32'h0C, 0, 1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 0, 0, 32'h0,         1, 1, 32'hC0DE0008);
    tbl[9]  = mk(0, 1, 32'h0C, 0, 1, 0, 32'h20, 32'h0,        1, 0, 0, 32'h0C, 0, 0, 32'h0,         1, 1, 32'hC0DE0008);
    tbl[10] = mk(0, 1, 32'h0C, 0, 1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 1, 1, 32'hC0DE0003,  0, 0, 32'h0);
    tbl[11] = mk(0, 1, 32'h0C, 0, 1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 0, 0, 32'h0,         1, 1, 32'hC0DE0008);
    tbl[12] = mk(0, 1, 32'h0C, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 1, 1, 32'h40, 0, 0, 32'h0,         1, 1, 32'hC0DE0008);
    tbl[13] = mk(0, 0, 32'h00, 0, 1, 0, 32'h40, 32'h0,        0, 1, 0, 32'h40, 0, 0, 32'h0,         1, 0, 32'h0);
    tbl[14] = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 0, 0, 32'h0,         1, 1, 32'hDEADBEEF);
    tbl[15] = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 0, 0, 32'h0,         0, 0, 32'h0);

    // Flush in the response cycle, flush in the grant cycle, data response under flush.
    flush_seq[0] = mk(0, 1, 32'h10, 0, 0, 0, 32'h00, 32'h0,   1, 0, 0, 32'h10, 0, 0, 32'h0,         0, 0, 32'h0);
    flush_seq[1] = mk(0, 0, 32'h00, 1, 1, 0, 32'h24, 32'h0,   0, 1, 0, 32'h24, 0, 0, 32'h0,         0, 0, 32'h0);
    flush_seq[2] = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 32'h0,   0, 0, 0, 32'h00, 0, 0, 32'h0,         1, 1, 32'hC0DE0009);
    flush_seq[3] = mk(0, 1, 32'h14, 1, 0, 0, 32'h00, 32'h0,   1, 0, 0, 32'h14, 0, 0, 32'h0,         0, 0, 32'h0);
    flush_seq[4] = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 32'h0,   0, 0, 0, 32'h00, 0, 0, 32'h0,         0, 0, 32'h0);
    flush_seq[5] = mk(0, 0, 32'h00, 0, 1, 0, 32'h28, 32'h0,   0, 1, 0, 32'h28, 0, 0, 32'h0,         0, 0, 32'h0);
    flush_seq[6] = mk(0, 0, 32'h00, 1, 0, 0, 32'h00, 32'h0,   0, 0, 0, 32'h00, 0, 0, 32'h0,         1, 1, 32'hC0DE000A);

    // Reset right after a data grant discards the response; next fetch is normal.
    rst_seq[0] = mk(0, 0, 32'h00, 0, 1, 0, 32'h2C, 32'h0,     0, 1, 0, 32'h2C, 0, 0, 32'h0,         0, 0, 32'h0);
    rst_seq[1] = mk(1, 1, 32'h00, 0, 1, 1, 32'h2C, 32'h5,     0, 0, 0, 32'h00, 0, 1, 32'h0,         0, 1, 32'h0);
    rst_seq[2] = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 32'h0,     0, 0, 0, 32'h00, 0, 1, 32'h0,         0, 1, 32'h0);
    rst_seq[3] = mk(0, 1, 32'h00, 0, 0, 0, 32'h00, 32'h0,     1, 0, 0, 32'h00, 0, 0, 32'h0,         0, 0, 32'h0);
    rst_seq[4] = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 32'h0,     0, 0, 0, 32'h00, 1, 1, 32'hC0DE0000,  0, 0, 32'h0);

    for (int i = 0; i < 16; i++) step(tbl[i], $sformatf("row%0d", i));
    for (int i = 0; i < 7; i++)  step(flush_seq[i], $sformatf("flush%0d", i));
    for (int i = 0; i < 5; i++)  step(rst_seq[i], $sformatf("reset%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3: max consecutive data grants while a fetch waits.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  fetch requester asks for a memory cycle.
REQ-006 if_addr  in  ADDR_W  fetch address (PC).
REQ-007 if_flush  in  1  branch/jump taken; discard any outstanding fetch response.
REQ-008 if_gnt  out  1  fetch request accepted this cycle; low means stall the PC.
REQ-009 if_rvalid  out  1  fetch response valid.
REQ-010 if_rdata  out  32  fetched word.
REQ-011 d_req  in  1  MEM-stage load/store request.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  32  store data.
REQ-015 d_size  in  2  access size, byte/half/word encoding from the shared package.
REQ-016 d_signed  in  1  sign-extend loads.
REQ-017 d_gnt  out  1  data request accepted this cycle.
REQ-018 d_rvalid  out  1  data response valid; also serves as the store acknowledge.
REQ-019 d_rdata  out  32  load data.
REQ-020 mem_en, mem_we  out  1 each  single-port memory strobe and write enable.
REQ-021 mem_addr  out  ADDR_W, mem_wdata  out  32, mem_size  out  2, mem_signed  out  1  memory command.
REQ-022 mem_rdata  in  32  memory read data, valid exactly 1 cycle after mem_en.

Function
REQ-023 The block shall grant at most one requester per cycle, and at most one grant shall be issued per cycle (mem_en = if_gnt | d_gnt).
REQ-024 Grants, mem_en, and the mem_* command fields shall be combinational from the requests and the registered state; the mem_* command fields shall carry the granted requester's fields.
REQ-025 Default priority shall be data over fetch.
REQ-026 A counter starve_cnt shall increment on each data grant while if_req is high and shall saturate at STARVE_MAX.
REQ-027 When starve_cnt == STARVE_MAX and if_req is high, fetch shall win the next cycle regardless of d_req.
REQ-028 starve_cnt shall clear on any fetch grant and in any cycle with if_req low.
REQ-029 A registered owner tag {NONE, IF, DATA} shall record the granted requester each cycle; it shall be NONE when no grant is issued.
REQ-030 Back-to-back grants shall be allowed every cycle; there shall be no bubble between accesses.
REQ-031 Responses shall follow a fixed 1-cycle latency: if owner==IF then if_rvalid=1 and if_rdata=mem_rdata; if owner==DATA then d_rvalid=1 and d_rdata=mem_rdata.
REQ-032 A fetch response shall be suppressed (if_rvalid=0) if if_flush is high in the grant cycle or in the response cycle.
REQ-033 if_flush shall not affect data grants or responses.
REQ-034 if_flush shall not block a fetch grant in the same cycle; that grant's response is dropped per REQ-032.
REQ-035 With no requests, mem_en shall be 0, the mem_* command fields shall be 0, and owner shall become NONE.
REQ-036 Stores shall produce d_rvalid=1 one cycle after d_gnt; d_rdata is don't-care for stores.

Reset
REQ-037 While rst is high, if_gnt, d_gnt, mem_en, and mem_we shall be 0.
REQ-038 On reset, owner shall be NONE, starve_cnt 0, if_rvalid and d_rvalid 0, and if_rdata and d_rdata 0.
REQ-039 A reset asserted with a response outstanding shall discard that response; no rvalid shall be produced in the cycle after reset deasserts.

Structure
REQ-040 A package mem_arb_pkg shall hold the owner enum, the d_size encodings (BYTE=00, HALF=01, WORD=10), and the STARVE_MAX default.
REQ-041 The starvation counter shall be one sub-module, arb_starve_ctr (inc, clr, sat output); all other logic shall be inline.

Verification
REQ-042 Only if_req=1, addr 0x00,0x04,0x08 on consecutive cycles -> if_gnt=1 each cycle; if_rvalid=1 one cycle later each, carrying the mem words at 0x00/0x04/0x08.
REQ-043 if_req and d_req both held high for 6 cycles, STARVE_MAX=3 -> grant sequence D,D,D,IF,D,D.
REQ-044 Store d_addr=0x40, d_wdata=0xDEADBEEF, d_size=WORD concurrent with fetch -> mem_we=1, addr 0x40 that cycle; d_rvalid=1 next cycle; a later load of 0x40 returns 0xDEADBEEF.
REQ-045 Fetch granted, if_flush=1 in the following cycle -> if_rvalid stays 0; a data response in the same cycle is unaffected.
REQ-046 rst asserted in the cycle after a data grant -> d_rvalid=0, all outputs at reset values; first grant after rst deasserts behaves normally.
